sim_run_ctrl: RTL
=================

// Module: sim_run_ctrl
// PURPOSE
//   Run controller that sits between the bench clock/reset and the mips core.
//   Stretches the incoming reset into a parametrised CPU reset pulse, then counts
//   cycles and retired instructions while the core runs.
//   Ends the run on a self-loop halt (same PC retired N times), an external halt,
//   or a cycle timeout. Reports status, counts and the halting PC.
//   Synthesizable; one instance per core under test.
// PARAMETERS
//   RST_CYCLES  10         cycles cpu_reset is held high after reset deasserts (>=1)
//   MAX_CYCLES  10000      RUN-state cycle budget before TIMEOUT (>=2)
//   HALT_REPEAT 4          consecutive retires of identical PC that mean halt (>=2)
//   PC_W        32         width of PC input and halt_pc
//   CNT_W       32         width of cycle_cnt / retire_cnt
// PORTS
//   clk         in   1      single clock, all logic on rising edge
//   reset       in   1      synchronous reset, ACTIVE-LOW
//   restart     in   1      pulse: re-run from HOLD; honoured only in HALTED/TIMEOUT
//   ext_halt    in   1      force HALTED from RUN
//   pc_valid    in   1      one instruction retires this cycle
//   pc_value    in   PC_W   PC of the retiring instruction (sampled when pc_valid)
//   cpu_reset   out  1      active-high reset to the core
//   running     out  1      state==RUN
//   done        out  1      state==HALTED or TIMEOUT
//   timed_out   out  1      state==TIMEOUT
//   state       out  2      00 HOLD, 01 RUN, 10 HALTED, 11 TIMEOUT
//   halt_pc     out  PC_W   PC at halt; 0 for ext_halt/timeout
//   cycle_cnt   out  CNT_W  cycles spent in RUN, saturating
//   retire_cnt  out  CNT_W  pc_valid count in RUN, saturating
// BEHAVIOUR
//   Reset (reset==0 at edge): state=HOLD, cpu_reset=1, all counters, halt_pc,
//     rst_ctr, repeat_ctr and last_pc valid flag cleared. Applies from any state,
//     including mid-RUN; takes priority over every other input.
//   HOLD: cpu_reset=1; rst_ctr++ each cycle; at rst_ctr==RST_CYCLES-1 -> RUN next
//     edge. cpu_reset is therefore high for exactly RST_CYCLES cycles after the
//     first edge with reset==1. Entering HOLD via restart clears counters/halt_pc.
//   RUN: cpu_reset=0; cycle_cnt++ each cycle (saturate at all-ones).
//     pc_valid: retire_cnt++ (saturating).
//       - last_pc valid and pc_value==last_pc: repeat_ctr++.
//       - otherwise: repeat_ctr=0.
//       - last_pc<=pc_value and last_pc is marked valid.
//     The first retire after HOLD never counts as a repeat.
//     Halt when a matching retire brings repeat_ctr to HALT_REPEAT-1: next state
//       HALTED, halt_pc<=pc_value.
//     ext_halt -> HALTED, halt_pc=0.
//     cycle_cnt==MAX_CYCLES-1 at the edge -> TIMEOUT.
//   Priority in the same cycle: PC halt > ext_halt > timeout. Counters still
//     update in the transition cycle.
//   HALTED/TIMEOUT: terminal; counters frozen, cpu_reset=0, pc_valid ignored.
//     restart -> HOLD.
//   restart is ignored in HOLD and RUN. ext_halt is ignored outside RUN.
//   Outputs are registered or decoded from the state register; no comb path from
//     inputs to outputs.
// TESTING
//   1 reset=0 for 3 cycles then 1 -> cpu_reset high exactly 10 cycles, then
//     running=1, cycle_cnt counts 1,2,3...
//   2 retire PCs 3000,3004,3008,3008,3008,3008 -> HALTED after the 4th 3008
//     (repeat=3); halt_pc=3008, retire_cnt=6.
//   3 no halt and MAX_CYCLES=50 -> TIMEOUT when cycle_cnt reaches 50;
//     timed_out=1, done=1, halt_pc=0.
//   4 ext_halt and the HALT_REPEAT-th matching retire in the same cycle ->
//     HALTED with halt_pc=matching PC. ext_halt together with the timeout edge
//     -> HALTED, not TIMEOUT.
//   5 reset=0 mid-RUN at cycle 20 -> next edge state=HOLD, cpu_reset=1,
//     counters 0. restart during RUN -> no effect.
//   6 restart pulse in TIMEOUT -> HOLD, counters cleared, new 10-cycle reset, RUN.
//     PC repeat from the previous run is not carried over.

Source files
------------

// File: rtl/sim_run_ctrl_if.sv
// Control/status bundle between a bench and the run controller.
// The bench (master) drives retire and run-control inputs; the controller (slave) reports status.
interface sim_run_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             restart;
    logic             ext_halt;
    logic             pc_valid;
    logic [PC_W-1:0]  pc_value;
    logic             cpu_reset;
    logic             running;
    logic             done;
    logic             timed_out;
    logic [1:0]       state;
    logic [PC_W-1:0]  halt_pc;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output restart, ext_halt, pc_valid, pc_value,
        input  cpu_reset, running, done, timed_out, state, halt_pc, cycle_cnt, retire_cnt
    );

    modport slave (
        input  restart, ext_halt, pc_valid, pc_value,
        output cpu_reset, running, done, timed_out, state, halt_pc, cycle_cnt, retire_cnt
    );
endinterface

// File: rtl/sim_run_ctrl.sv
// Run controller for a core under test: stretches reset into a CPU reset pulse, then
// counts run cycles and retires until a self-loop halt, external halt or timeout.
module sim_run_ctrl #(
    parameter int RST_CYCLES  = 10,
    parameter int MAX_CYCLES  = 10000,
    parameter int HALT_REPEAT = 4,
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    sim_run_ctrl_if.slave bus
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int HW = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'b00,
        S_RUN     = 2'b01,
        S_HALTED  = 2'b10,
        S_TIMEOUT = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [RW-1:0]    rst_ctr_q, rst_ctr_d;
    logic [HW-1:0]    repeat_ctr_q, repeat_ctr_d;
    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic             last_vld_q, last_vld_d;
    logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [HW-1:0]    repeat_inc;
    logic             pc_hit;

    always_comb begin
        state_d      = state_q;
        rst_ctr_d    = rst_ctr_q;
        repeat_ctr_d = repeat_ctr_q;
        last_pc_d    = last_pc_q;
        last_vld_d   = last_vld_q;
        halt_pc_d    = halt_pc_q;
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        repeat_inc   = repeat_ctr_q + 1'b1;
        pc_hit       = 1'b0;

        unique case (state_q)
            S_HOLD: begin
                rst_ctr_d = rst_ctr_q + 1'b1;
                if (rst_ctr_q == RW'(RST_CYCLES - 1)) begin
                    state_d   = S_RUN;
                    rst_ctr_d = '0;
                end
            end
            S_RUN: begin
                cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
                if (bus.pc_valid) begin
                    retire_cnt_d = (retire_cnt_q == '1) ? retire_cnt_q : retire_cnt_q + 1'b1;
                    // last_vld gates the match so the first retire of a run never counts
                    if (last_vld_q && bus.pc_value == last_pc_q) begin
                        repeat_ctr_d = repeat_inc;
                        pc_hit       = (repeat_inc == HW'(HALT_REPEAT - 1));
                    end else begin
                        repeat_ctr_d = '0;
                    end
                    last_pc_d  = bus.pc_value;
                    last_vld_d = 1'b1;
                end
                if (pc_hit) begin
                    state_d   = S_HALTED;
                    halt_pc_d = bus.pc_value;
                end else if (bus.ext_halt) begin
                    state_d   = S_HALTED;
                    halt_pc_d = '0;
                end else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: begin
                if (bus.restart) begin
                    state_d      = S_HOLD;
                    rst_ctr_d    = '0;
                    repeat_ctr_d = '0;
                    last_pc_d    = '0;
                    last_vld_d   = 1'b0;
                    halt_pc_d    = '0;
                    cycle_cnt_d  = '0;
                    retire_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_HOLD;
            rst_ctr_q    <= '0;
            repeat_ctr_q <= '0;
            last_pc_q    <= '0;
            last_vld_q   <= 1'b0;
            halt_pc_q    <= '0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            rst_ctr_q    <= rst_ctr_d;
            repeat_ctr_q <= repeat_ctr_d;
            last_pc_q    <= last_pc_d;
            last_vld_q   <= last_vld_d;
            halt_pc_q    <= halt_pc_d;
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.cpu_reset  = (state_q == S_HOLD);
    assign bus.running    = (state_q == S_RUN);
    assign bus.done       = (state_q == S_HALTED) || (state_q == S_TIMEOUT);
    assign bus.timed_out  = (state_q == S_TIMEOUT);
    assign bus.state      = state_q;
    assign bus.halt_pc    = halt_pc_q;
    assign bus.cycle_cnt  = cycle_cnt_q;
    assign bus.retire_cnt = retire_cnt_q;
endmodule
